// File: rtl/pattern_101_detector.sv
// Serial pattern detector: shifts in one bit per clock and raises a registered
// one-cycle flag each time the last PATTERN_W bits equal PATTERN, with a saturating match count.
module pattern_101_detector #(
    parameter int                   PATTERN_W = 3,
    parameter logic [PATTERN_W-1:0] PATTERN   = 3'b101,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             val_i,
    output logic             val_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] hist, hist_n;
    logic [FILL_W-1:0]    fill, fill_n;
    logic                 hit;

    // fill guards against the reset zeros in hist ever forming part of a match
    always_comb begin
        hist_n = {hist[PATTERN_W-2:0], val_i};
        fill_n = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        hit    = (fill_n == FILL_FULL) && (hist_n == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            val_o       <= 1'b0;
            match_cnt_o <= '0;
        end else begin
            val_o <= hit;
            if (hit && !OVERLAP) begin
                fill <= '0;
                hist <= '0;
            end else begin
                fill <= fill_n;
                hist <= hist_n;
            end
            if (hit && (match_cnt_o != {CNT_W{1'b1}}))
                match_cnt_o <= match_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pattern_101_detector.sv
// Bench for pattern_101_detector: three configurations share one bit stream and are
// checked every cycle against a queue-based model, plus directed literal expectations.
module tb_pattern_101_detector;

    logic clk = 1'b0;
    logic rst;
    logic val_i;

    // 0: overlap, 8-bit count; 1: non-overlap; 2: overlap, 2-bit count
    logic       v_ov, v_no, v_sat;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pattern_101_detector #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .val_i(val_i), .val_o(v_ov), .match_cnt_o(c_ov));
    pattern_101_detector #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .val_i(val_i), .val_o(v_no), .match_cnt_o(c_no));
    pattern_101_detector #(.PATTERN_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .val_i(val_i), .val_o(v_sat), .match_cnt_o(c_sat));

    // Model: bits received since the last restart, matched by value of the last three.
    int  q[3][$];
    int  exp_v[3];
    int  exp_c[3];
    bit  started = 1'b0;
    int  cmax[3] = '{255, 255, 3};
    bit  ovl[3]  = '{1'b1, 1'b0, 1'b1};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst === 1'b1) begin
                q[k].delete();
                exp_v[k] = 0;
                exp_c[k] = 0;
            end else if (started) begin
                int n;
                bit h;
                q[k].push_back(val_i === 1'b1 ? 1 : 0);
                if (q[k].size() > 8) void'(q[k].pop_front());
                n = q[k].size();
                h = (n >= 3) && (q[k][n-3] * 4 + q[k][n-2] * 2 + q[k][n-1] == 5);
                exp_v[k] = h ? 1 : 0;
                if (h) begin
                    if (exp_c[k] < cmax[k]) exp_c[k]++;
                    if (!ovl[k]) q[k].delete();
                end
            end
        end
        if (rst === 1'b1) started = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("ov.val",  int'(v_ov),  exp_v[0]);
            chk("ov.cnt",  int'(c_ov),  exp_c[0]);
            chk("no.val",  int'(v_no),  exp_v[1]);
            chk("no.cnt",  int'(c_no),  exp_c[1]);
            chk("sat.val", int'(v_sat), exp_v[2]);
            chk("sat.cnt", int'(c_sat), exp_c[2]);
        end
    end

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        rst   = r;
        val_i = b;
        @(posedge clk);
        #1;
    endtask

    task automatic bits(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) step(1'b0, v[i]);
    endtask

    initial begin
        rst   = 1'b0;
        val_i = 1'b0;
        step(1'b1, 1'bx);
        chk("reset.val", int'(v_ov), 0);
        chk("reset.cnt", int'(c_ov), 0);

        // basic: 1,0,1 -> pulse; then 0 -> low
        bits(3, 32'b101);
        chk("basic.pulse", int'(v_ov), 1);
        bits(1, 32'b0);
        chk("basic.low", int'(v_ov), 0);
        chk("basic.cnt", int'(c_ov), 1);

        // overlap vs non-overlap on 10101
        step(1'b1, 1'b0);
        bits(5, 32'b10101);
        chk("ovl.pulse2", int'(v_ov), 1);
        chk("ovl.cnt",    int'(c_ov), 2);
        chk("novl.nopulse", int'(v_no), 0);
        chk("novl.cnt",     int'(c_no), 1);

        // near misses
        step(1'b1, 1'b0);
        bits(9, 32'b110010011);
        chk("miss.cnt.ov", int'(c_ov), 0);
        chk("miss.cnt.no", int'(c_no), 0);

        // mid-stream reset discards the pending "10"
        step(1'b1, 1'b0);
        bits(2, 32'b10);
        step(1'b1, 1'b1);
        bits(1, 32'b1);
        chk("midrst.nopulse", int'(v_ov), 0);
        bits(2, 32'b01);
        chk("midrst.pulse", int'(v_ov), 1);
        chk("midrst.cnt",   int'(c_ov), 1);

        // reset while val_o is high
        step(1'b1, 1'b0);
        chk("rst_on_hit.val", int'(v_ov), 0);

        // five overlapping matches saturate the 2-bit counter
        bits(11, 32'b10101010101);
        chk("sat.cnt3",  int'(c_sat), 3);
        chk("sat.pulse", int'(v_sat), 1);
        chk("sat.wide",  int'(c_ov),  5);

        // random soak with occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 31) == 0) step(1'b1, 1'bx);
            else step(1'b0, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
